// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int INDEX_W    = 5;
  localparam int TAG_W      = 22;
  localparam int WORD_SEL_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

endpackage

// File: rtl/icache_sram.sv
// Valid/tag/data storage: combinational read by index, synchronous write,
// valid bits cleared asynchronously on reset.
module icache_sram
  import icache_pkg::*;
#(
  parameter int LINE_W    = 256,
  parameter int NUM_LINES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [LINE_W-1:0]  i_wdata,
  input  logic [INDEX_W-1:0] i_ridx,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [LINE_W-1:0]  o_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data need no reset; the valid bit qualifies them.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-fetch responder: zero-latency hit path, stall and line refill
// over an enable/ack memory handshake on a miss.
//
// state | meaning
// IDLE  | lookup current addr_i; a miss latches the line address
// READ  | refill request held until mem_ack_i installs the line
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int NUM_LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       inst_o,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_t             r_state;
  logic [TAG_W-1:0]   r_miss_tag;
  logic [INDEX_W-1:0] r_miss_index;
  logic               r_mem_enable;
  logic [ADDR_W-1:0]  r_mem_addr;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_index;
  logic [WORD_SEL_W-1:0] w_word;
  logic                  w_valid;
  logic [TAG_W-1:0]      w_rtag;
  logic [LINE_W-1:0]     w_line;
  logic                  w_hit;
  logic                  w_we;

  assign w_tag   = addr_i[ADDR_W-1 -: TAG_W];
  assign w_index = addr_i[OFFSET_W +: INDEX_W];
  assign w_word  = addr_i[2 +: WORD_SEL_W];

  assign w_we = (r_state == ST_READ) && mem_ack_i;

  icache_sram #(
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_we),
    .i_widx  (r_miss_index),
    .i_wtag  (r_miss_tag),
    .i_wdata (mem_data_i),
    .i_ridx  (w_index),
    .o_valid (w_valid),
    .o_tag   (w_rtag),
    .o_data  (w_line)
  );

  assign w_hit = req_i && w_valid && (w_rtag == w_tag);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_mem_enable <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i && !w_hit) begin
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
            r_mem_enable <= 1'b1;
            r_mem_addr   <= {w_tag, w_index, {OFFSET_W{1'b0}}};
            r_state      <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_ack_i) begin
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the combinational outputs so they drop in the reset cycle itself.
  assign stall_o      = !rst_i && ((r_state == ST_READ) || (req_i && !w_hit));
  assign inst_o       = (!rst_i && (r_state == ST_IDLE) && w_hit) ?
                        w_line[{w_word, 5'b00000} +: 32] : 32'h0;
  assign mem_enable_o = r_mem_enable;
  assign mem_addr_o   = r_mem_addr;

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: vector table, directed corner cases,
// and randomized traffic against a line-residency reference model.
module tb_icache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic [31:0]  addr_i;
  logic [31:0]  inst_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  int model_line [32];
  bit pend;
  int pend_line;

  always #5 clk_i = ~clk_i;

  icache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        stall;
    logic [31:0] inst;
    logic        en;
    logic [31:0] maddr;
  } vec_t;

  vec_t tv[$];

  // Off-chip memory image: each word holds its own byte address xor 0x37.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h0000_0037;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b00000};
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(base + 32'(w * 4));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_line[i] = -1;
    pend = 1'b0;
    pend_line = 0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return model_line[int'(a[9:5])] == int'(a[31:5]);
  endfunction

  task automatic model_expect(input logic req, input logic [31:0] a,
                              output logic stall, output logic [31:0] inst,
                              output logic en, output logic [31:0] maddr);
    if (pend) begin
      stall = 1'b1; inst = 32'h0; en = 1'b1; maddr = 32'(pend_line) << 5;
    end else begin
      en = 1'b0; maddr = 32'h0;
      if (req && model_hit(a)) begin
        stall = 1'b0; inst = mem_word(a);
      end else begin
        stall = req; inst = 32'h0;
      end
    end
  endtask

  task automatic model_edge(input logic req, input logic [31:0] a, input logic ack);
    if (pend) begin
      if (ack) begin
        model_line[pend_line & 31] = pend_line;
        pend = 1'b0;
      end
    end else if (req && !model_hit(a)) begin
      pend = 1'b1;
      pend_line = int'(a[31:5]);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] a, input logic ack);
    @(negedge clk_i);
    req_i      = req;
    addr_i     = a;
    mem_ack_i  = ack;
    mem_data_i = mem_line(mem_addr_o);
    #1;
  endtask

  task automatic mstep(input string name, input logic req, input logic [31:0] a,
                       input logic ack);
    logic s, e;
    logic [31:0] ins, ma;
    drive(req, a, ack);
    model_expect(req, a, s, ins, e, ma);
    chk({name, ".stall"}, 32'(stall_o), 32'(s));
    chk({name, ".inst"}, inst_o, ins);
    chk({name, ".en"}, 32'(mem_enable_o), 32'(e));
    chk({name, ".maddr"}, mem_addr_o, ma);
    model_edge(req, a, ack);
  endtask

  task automatic do_reset(input string name, input logic req, input logic [31:0] a,
                          input logic ack);
    @(negedge clk_i);
    rst_i = 1'b1; req_i = req; addr_i = a; mem_ack_i = ack;
    mem_data_i = mem_line(a);
    #1;
    chk({name, ".stall"}, 32'(stall_o), 32'h0);
    chk({name, ".en"}, 32'(mem_enable_o), 32'h0);
    chk({name, ".inst"}, inst_o, 32'h0);
    chk({name, ".maddr"}, mem_addr_o, 32'h0);
    model_clear();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic addv(input logic req, input logic [31:0] a, input logic ack,
                      input logic s, input logic [31:0] ins, input logic e,
                      input logic [31:0] ma);
    vec_t v;
    v.req = req; v.addr = a; v.ack = ack; v.stall = s; v.inst = ins; v.en = e; v.maddr = ma;
    tv.push_back(v);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    mstep("idle_noreq", 1'b0, 32'h0, 1'b0);
    mstep("idle_noreq2", 1'b0, 32'h0, 1'b0);

    // Reset mid-simulation with a fetch pending, then first miss.
    do_reset("reset", 1'b1, 32'h0, 1'b0);
    mstep("miss0", 1'b1, 32'h0, 1'b0);
    chk("miss0_stall_const", 32'(stall_o), 32'h1);
    mstep("miss0_fill", 1'b1, 32'h0, 1'b1);

    // Cold miss at 0x24 with ack in the third READ cycle, then a line walk.
    addv(1, 32'h24, 0, 1, 32'h0, 0, 32'h0);
    addv(1, 32'h24, 0, 1, 32'h0, 1, 32'h20);
    addv(1, 32'h24, 0, 1, 32'h0, 1, 32'h20);
    addv(1, 32'h24, 1, 1, 32'h0, 1, 32'h20);
    addv(1, 32'h24, 0, 0, 32'h13, 0, 32'h0);
    for (int w = 0; w < 8; w++)
      addv(1, 32'h20 + 32'(4 * w), 0, 0, (32'h20 + 32'(4 * w)) ^ 32'h37, 0, 32'h0);
    addv(1, 32'h40, 0, 1, 32'h0, 0, 32'h0);
    addv(1, 32'h40, 1, 1, 32'h0, 1, 32'h40);
    addv(1, 32'h40, 0, 0, 32'h77, 0, 32'h0);
    addv(0, 32'h40, 0, 0, 32'h0, 0, 32'h0);
    addv(1, 32'h3F, 0, 0, 32'h0B, 0, 32'h0);
    foreach (tv[i]) begin
      drive(tv[i].req, tv[i].addr, tv[i].ack);
      chk($sformatf("tv%0d.stall", i), 32'(stall_o), 32'(tv[i].stall));
      chk($sformatf("tv%0d.inst", i), inst_o, tv[i].inst);
      chk($sformatf("tv%0d.en", i), 32'(mem_enable_o), 32'(tv[i].en));
      chk($sformatf("tv%0d.maddr", i), mem_addr_o, tv[i].maddr);
      model_edge(tv[i].req, tv[i].addr, tv[i].ack);
    end

    // Conflict eviction on index 0.
    mstep("cf_hit0", 1'b1, 32'h0, 1'b0);
    chk("cf_hit0_inst", inst_o, 32'h37);
    mstep("cf_miss400", 1'b1, 32'h400, 1'b0);
    mstep("cf_fill400", 1'b1, 32'h400, 1'b1);
    mstep("cf_hit400", 1'b1, 32'h41C, 1'b0);
    chk("cf_hit400_inst", inst_o, 32'h42B);
    mstep("cf_remiss0", 1'b1, 32'h0, 1'b0);
    chk("cf_remiss0_stall", 32'(stall_o), 32'h1);
    mstep("cf_fill0", 1'b1, 32'h0, 1'b1);
    mstep("cf_hit0b", 1'b1, 32'h0, 1'b0);

    // Address change during READ.
    mstep("ac_miss100", 1'b1, 32'h100, 1'b0);
    mstep("ac_read", 1'b1, 32'h200, 1'b0);
    chk("ac_read_maddr", mem_addr_o, 32'h100);
    mstep("ac_fill100", 1'b1, 32'h200, 1'b1);
    mstep("ac_miss200", 1'b1, 32'h200, 1'b0);
    mstep("ac_read200", 1'b1, 32'h200, 1'b0);
    chk("ac_read200_maddr", mem_addr_o, 32'h200);
    mstep("ac_fill200", 1'b1, 32'h200, 1'b1);
    mstep("ac_hit100", 1'b1, 32'h100, 1'b0);
    chk("ac_hit100_inst", inst_o, 32'h137);

    // req_i dropping during READ still installs the line.
    mstep("rd_miss300", 1'b1, 32'h300, 1'b0);
    mstep("rd_drop", 1'b0, 32'h300, 1'b0);
    mstep("rd_fill", 1'b0, 32'h300, 1'b1);
    mstep("rd_hit300", 1'b1, 32'h304, 1'b0);
    chk("rd_hit300_stall", 32'(stall_o), 32'h0);

    // Stray ack in IDLE installs nothing.
    mstep("sa_ack", 1'b0, 32'h500, 1'b1);
    mstep("sa_miss500", 1'b1, 32'h500, 1'b0);
    chk("sa_miss500_stall", 32'(stall_o), 32'h1);
    mstep("sa_fill500", 1'b1, 32'h500, 1'b1);

    // Reset during READ aborts the refill, even with an ack offered.
    mstep("ra_miss600", 1'b1, 32'h600, 1'b0);
    mstep("ra_read", 1'b1, 32'h600, 1'b0);
    chk("ra_read_en", 32'(mem_enable_o), 32'h1);
    do_reset("ra_reset", 1'b1, 32'h600, 1'b1);
    mstep("ra_remiss", 1'b1, 32'h600, 1'b0);
    chk("ra_remiss_stall", 32'(stall_o), 32'h1);
    mstep("ra_fill", 1'b1, 32'h600, 1'b1);

    // Randomized traffic over a small address pool to mix hits, misses and conflicts.
    for (int n = 0; n < 3000; n++) begin
      logic        rq, ak;
      logic [31:0] a;
      rq = ($urandom_range(0, 7) != 0);
      a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
           (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      ak = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) do_reset("rnd_reset", rq, a, ak);
      else mstep("rnd", rq, a, ak);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
